query_patch_sched: RTL and testbench

QUERY_PATCH_SCHED -- requirements
Module: query_patch_sched

---
 rtl/query_patch_sched.sv | 165 ++++++++++++++++
 tb/tb_query_patch_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/query_patch_sched.sv
// Query patch scheduler: loads N patches into a dual-port query memory, then streams them back.
// Optional port-0 debug read path enabled by defining QUERY_PATCH_SCHED_DBG_READ_EN.
module query_patch_sched #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned PATCH_SIZE = 5,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DEPTH      = 512
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDR_WIDTH:0]                cfg_num,
  output logic                               busy,
  output logic                               done,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0]   in_patch,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0]   out_patch,
  output logic                               csb0,
  output logic                               web0,
  output logic [ADDR_WIDTH-1:0]              addr0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0]   wpatch0,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0]   rpatch0,
  output logic                               csb1,
  output logic [ADDR_WIDTH-1:0]              addr1,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0]   rpatch1,
  input  logic                               dbg_req,
  input  logic [ADDR_WIDTH-1:0]              dbg_addr,
  output logic                               dbg_valid,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0]   dbg_rdata
);

  localparam int unsigned W  = DATA_WIDTH * PATCH_SIZE;
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   num_q;
  logic [CW-1:0]   wr_ptr_q;
  logic [CW-1:0]   rd_ptr_q;
  logic [CW-1:0]   out_cnt_q;
  logic [W-1:0]    fifo_q [3];
  logic [1:0]      fifo_wr_idx_q;
  logic [1:0]      fifo_rd_idx_q;
  logic [1:0]      fifo_cnt_q;
  logic            inflight_q;

  logic [CW-1:0]   n_lat;
  logic [2:0]      occ;
  logic            wr_fire;
  logic            rd_fire;
  logic            dbg_fire;
  logic            pop;

  function automatic logic [1:0] idx_inc(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign n_lat     = (cfg_num > DEPTH_C) ? DEPTH_C : cfg_num;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_patch = fifo_q[fifo_rd_idx_q];
  assign pop       = out_valid && out_ready;

  // Occupancy the FIFO will have once in-flight data lands, net of this cycle's pop.
  assign occ     = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
  assign wr_fire = rst_n && in_valid && (state_q == S_LOAD);
  assign rd_fire = rst_n && (state_q == S_STREAM) && (rd_ptr_q < num_q) && (occ < 3'd3);

`ifdef QUERY_PATCH_SCHED_DBG_READ_EN
  logic dbg_valid_q;

  assign dbg_fire  = rst_n && (state_q == S_IDLE) && dbg_req && !start;
  assign dbg_valid = dbg_valid_q;
  assign dbg_rdata = dbg_valid_q ? rpatch0 : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) dbg_valid_q <= 1'b0;
    else        dbg_valid_q <= dbg_fire;
  end
`else
  logic unused_dbg;

  assign dbg_fire   = 1'b0;
  assign dbg_valid  = 1'b0;
  assign dbg_rdata  = '0;
  assign unused_dbg = ^{dbg_req, dbg_addr, rpatch0};
`endif

  // Memory port strobes follow the accepting handshake in the same cycle.
  always_comb begin
    csb0    = 1'b1;
    web0    = 1'b1;
    addr0   = '0;
    wpatch0 = '0;
    csb1    = 1'b1;
    addr1   = '0;
    if (wr_fire) begin
      csb0    = 1'b0;
      web0    = 1'b0;
      addr0   = wr_ptr_q[ADDR_WIDTH-1:0];
      wpatch0 = in_patch;
    end else if (dbg_fire) begin
      csb0  = 1'b0;
      addr0 = dbg_addr;
    end
    if (rd_fire) begin
      csb1  = 1'b0;
      addr1 = rd_ptr_q[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      num_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      out_cnt_q     <= '0;
      fifo_wr_idx_q <= '0;
      fifo_rd_idx_q <= '0;
      fifo_cnt_q    <= '0;
      inflight_q    <= 1'b0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      inflight_q <= rd_fire;
      fifo_cnt_q <= fifo_cnt_q + 2'(inflight_q) - 2'(pop);
      if (inflight_q) begin
        fifo_q[fifo_wr_idx_q] <= rpatch1;
        fifo_wr_idx_q         <= idx_inc(fifo_wr_idx_q);
      end
      if (pop)     fifo_rd_idx_q <= idx_inc(fifo_rd_idx_q);
      if (pop)     out_cnt_q     <= out_cnt_q + CW'(1);
      if (wr_fire) wr_ptr_q      <= wr_ptr_q + CW'(1);
      if (rd_fire) rd_ptr_q      <= rd_ptr_q + CW'(1);

      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_q     <= n_lat;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_cnt_q <= '0;
            state_q   <= (n_lat == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (wr_fire && (wr_ptr_q == num_q - CW'(1))) state_q <= S_STREAM;
        end
        S_STREAM: begin
          if (pop && (out_cnt_q == num_q - CW'(1))) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_query_patch_sched.sv
// Bench for query_patch_sched: directed jobs against a job-level model of writes, reads and outputs.
module tb_query_patch_sched;

  localparam int unsigned DW    = 11;
  localparam int unsigned PS    = 5;
  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned W     = DW * PS;
  localparam int unsigned CW    = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_num = '0;
  logic          busy, done;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_patch = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_patch;
  logic          csb0, web0, csb1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wpatch0;
  logic [W-1:0]  rpatch0 = '0;
  logic [W-1:0]  rpatch1 = '0;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic          dbg_valid;
  logic [W-1:0]  dbg_rdata;

  query_patch_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num(cfg_num),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_patch(in_patch),
    .out_valid(out_valid), .out_ready(out_ready), .out_patch(out_patch),
    .csb0(csb0), .web0(web0), .addr0(addr0), .wpatch0(wpatch0), .rpatch0(rpatch0),
    .csb1(csb1), .addr1(addr1), .rpatch1(rpatch1),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous dual-port query memory: read data valid the cycle after select.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!csb0 && !web0) mem[addr0] <= wpatch0;
    if (!csb0 && web0)  rpatch0 <= mem[addr0];
    if (!csb1)          rpatch1 <= mem[addr1];
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Job model state, owned by the monitor.
  logic [W-1:0] job_data [DEPTH];
  bit           active = 1'b0;
  int           mN = 0;
  int           wr_n = 0, rd_n = 0, out_n = 0, pend = 0, max_pend = 0;
  int           mem_acc = 0, done_cnt = 0;
  int           cyc = 0, last_wr_cyc = 0, ov_lat = -1;
  int           first_pop_cyc = 0, last_pop_cyc = 0;
  int           last_wr_addr = -1, last_rd_addr = -1;
  logic [W-1:0] first_pop = '0, last_pop = '0, prev_patch = '0;
  bit           prev_stall = 1'b0;

  initial begin : monitor
    int  wr_before;
    bit  act_before, exp_done, wr_act, dbg_exp, exp_ov;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        active     = 1'b0;
        prev_stall = 1'b0;
      end else begin
        wr_before  = wr_n;
        act_before = active;
        chk("busy", busy, active);
        chk("in_ready", in_ready, active && (wr_n < mN));
        exp_done = active && (wr_n == mN) && (out_n == mN);
        chk("done", done, exp_done);
        if (done) done_cnt++;

        wr_act = in_valid && in_ready;
        chk("port0_write", !csb0 && !web0, wr_act);
        if (wr_act && wr_n < mN) begin
          chk("addr0", addr0, wr_n);
          chk("wpatch0", wpatch0, job_data[wr_n]);
          last_wr_addr = addr0;
          wr_n++;
          mem_acc++;
          if (wr_n == mN) last_wr_cyc = cyc;
        end

`ifdef QUERY_PATCH_SCHED_DBG_READ_EN
        dbg_exp = !active && dbg_req && !start;
`else
        dbg_exp = 1'b0;
`endif
        chk("port0_read", !csb0 && web0, dbg_exp);
        if (!csb0 && web0) mem_acc++;

        if (!csb1) begin
          chk("read_allowed", active && (wr_before == mN) && (rd_n < mN), 1);
          chk("addr1", addr1, rd_n);
          last_rd_addr = addr1;
          rd_n++;
          pend++;
          mem_acc++;
        end

        // Output runs continuously from two cycles after stream entry until N popped.
        exp_ov = active && (mN > 0) && (wr_before == mN) && (out_n < mN) && (cyc >= last_wr_cyc + 3);
        chk("out_valid", out_valid, exp_ov);
        if (out_valid && ov_lat < 0) ov_lat = cyc - last_wr_cyc;
        if (prev_stall) chk("out_hold", out_patch, prev_patch);
        if (out_valid && out_ready && out_n < mN) begin
          chk("out_patch", out_patch, job_data[out_n]);
          if (out_n == 0) begin
            first_pop     = out_patch;
            first_pop_cyc = cyc;
          end
          last_pop     = out_patch;
          last_pop_cyc = cyc;
          out_n++;
          pend--;
        end
        if (pend > max_pend) max_pend = pend;
        chk("occupancy", pend <= 3, 1);
        prev_stall = out_valid && !out_ready;
        prev_patch = out_patch;

        if (exp_done) active = 1'b0;
        if (start && !act_before) begin
          active   = 1'b1;
          mN       = (int'(cfg_num) > DEPTH) ? DEPTH : int'(cfg_num);
          wr_n = 0; rd_n = 0; out_n = 0; pend = 0; max_pend = 0;
          mem_acc = 0; done_cnt = 0; ov_lat = -1;
          last_wr_cyc = 0; last_wr_addr = -1; last_rd_addr = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_dbg_valid"}, dbg_valid, 0);
    chk({tag, "_csb0"}, csb0, 1);
    chk({tag, "_web0"}, web0, 1);
    chk({tag, "_csb1"}, csb1, 1);
    chk({tag, "_addr0"}, addr0, 0);
    chk({tag, "_addr1"}, addr1, 0);
  endtask

  // Start a job, load N patches back-to-back, then drain; abort_after>0 stops after that many outputs.
  task automatic run_job(input int cfg, input int base, input bit bp, input int abort_after,
                         output int stream_cycles);
    int n, k, guard;
    bit [3:0] pat;
    pat = 4'b1001;
    n = (cfg > DEPTH) ? DEPTH : cfg;
    for (int i = 0; i < n; i++) job_data[i] = W'(base + i);
    cfg_num = CW'(cfg);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_patch = job_data[i];
      guard = 0;
      while (!in_ready && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) begin
        chk("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        stream_cycles = -1;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    in_patch = '0;
    k = 0;
    while (!done && k < 4 * n + 50) begin
      if (abort_after > 0 && out_n >= abort_after) break;
      out_ready = bp ? pat[k % 4] : 1'b1;
      tick();
      k++;
    end
    stream_cycles = k;
    if (abort_after == 0) begin
      chk("done_reached", done, 1);
      tick();
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int sc;
    repeat (3) tick();
    chk_reset("por");
    rst_n = 1'b1;
    tick();

    // Basic job: 5 patches 0x1..0x5.
    run_job(5, 1, 1'b0, 0, sc);
    chk("basic_writes", wr_n, 5);
    chk("basic_last_wr_addr", last_wr_addr, 4);
    chk("basic_outputs", out_n, 5);
    chk("basic_first_patch", first_pop, 55'h1);
    chk("basic_last_patch", last_pop, 55'h5);
    chk("basic_first_valid_lat", ov_lat, 3);
    chk("basic_consecutive", last_pop_cyc - first_pop_cyc, 4);
    chk("basic_done_pulses", done_cnt, 1);
    chk("basic_busy_after", busy, 0);

    // Backpressure: 8 patches 0x23..0x2A with out_ready 1-0-0-1.
    run_job(8, 'h23, 1'b1, 0, sc);
    chk("bp_outputs", out_n, 8);
    chk("bp_last_patch", last_pop, 55'h2A);
    chk("bp_max_occ_le3", max_pend <= 3, 1);
    chk("bp_done_pulses", done_cnt, 1);

    // Debug read of address 7 (holds 0x2A from the previous job).
    dbg_addr = AW'(7);
    dbg_req  = 1'b1;
    tick();
    dbg_req = 1'b0;
`ifdef QUERY_PATCH_SCHED_DBG_READ_EN
    chk("dbg_valid", dbg_valid, 1);
    chk("dbg_rdata", dbg_rdata, 55'h2A);
`else
    chk("dbg_valid_off", dbg_valid, 0);
    chk("dbg_rdata_off", dbg_rdata, 0);
`endif
    tick();
    chk("dbg_valid_clear", dbg_valid, 0);

    // Zero-length job: done on the cycle right after the start edge, no memory traffic.
    run_job(0, 0, 1'b0, 0, sc);
    chk("zero_stream_cycles", sc, 0);
    chk("zero_mem_access", mem_acc, 0);
    chk("zero_done_pulses", done_cnt, 1);

    // Oversized job clamps to DEPTH.
    run_job(600, 'h100, 1'b0, 0, sc);
    chk("big_writes", wr_n, 512);
    chk("big_last_wr_addr", last_wr_addr, 511);
    chk("big_last_rd_addr", last_rd_addr, 511);
    chk("big_outputs", out_n, 512);
    chk("big_last_patch", last_pop, 55'h2FF);

    // Reset after 3 outputs, then a clean 2-patch job.
    run_job(8, 'h40, 1'b0, 3, sc);
    chk("abort_out_n", out_n, 3);
    rst_n     = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_reset("midrst");
    rst_n = 1'b1;
    tick();
    chk_reset("postrst");
    run_job(2, 'h50, 1'b0, 0, sc);
    chk("post_outputs", out_n, 2);
    chk("post_first_patch", first_pop, 55'h50);
    chk("post_last_patch", last_pop, 55'h51);
    chk("post_done_pulses", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
